// File: rtl/counter_chain_pkg.sv
// Shared types and helpers for the counter-chain checker.
// Optional error-capture outputs are enabled by defining CCC_ERRLOG_EN.
package counter_chain_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Fibonacci LFSR tap positions (1-based bit numbers).
    localparam int LFSR_TAP_A = 32;
    localparam int LFSR_TAP_B = 22;
    localparam int LFSR_TAP_C = 2;
    localparam int LFSR_TAP_D = 1;

    // CL operand width of the evaluated wrapper; the checker's LENGTH must match.
    localparam int CCC_LENGTH = 5;
    localparam int CCC_SUM_W  = 2*CCC_LENGTH + 3;

    // Expected wrapper result: four CL words, CL_10 at weight 2, ones of C0, C1 at weight 2.
    function automatic logic [CCC_SUM_W-1:0] golden_sum(
        input logic [4:0]            c0,
        input logic                  c1,
        input logic [CCC_LENGTH-1:0] cl00,
        input logic [CCC_LENGTH-1:0] cl01,
        input logic [CCC_LENGTH-1:0] cl02,
        input logic [CCC_LENGTH-1:0] cl03,
        input logic [CCC_LENGTH-1:0] cl10
    );
        logic [CCC_SUM_W-1:0] acc;
        acc = CCC_SUM_W'(cl00) + CCC_SUM_W'(cl01) + CCC_SUM_W'(cl02) + CCC_SUM_W'(cl03);
        acc = acc + (CCC_SUM_W'(cl10) << 1) + (CCC_SUM_W'(c1) << 1);
        for (int i = 0; i < 5; i++) begin
            acc = acc + CCC_SUM_W'(c0[i]);
        end
        return acc;
    endfunction

endpackage

// File: rtl/counter_chain_checker_if.sv
// Operand/result bus between the checker and the counter-chain wrapper.
// Optional error-capture outputs (checker side) are enabled by CCC_ERRLOG_EN.
interface counter_chain_checker_if #(
    parameter int LENGTH = 5
);
    logic [4:0]          C0;
    logic                C1;
    logic [LENGTH-1:0]   CL_00;
    logic [LENGTH-1:0]   CL_01;
    logic [LENGTH-1:0]   CL_02;
    logic [LENGTH-1:0]   CL_03;
    logic [LENGTH-1:0]   CL_10;
    logic [2*LENGTH+2:0] O;

    // Checker side: drives operands, observes the wrapper result.
    modport master (
        output C0, C1, CL_00, CL_01, CL_02, CL_03, CL_10,
        input  O
    );

    // Wrapper side.
    modport slave (
        input  C0, C1, CL_00, CL_01, CL_02, CL_03, CL_10,
        output O
    );
endinterface

// File: rtl/counter_chain_lfsr.sv
// Fibonacci LFSR stimulus source: seed load, step enable, low OPS_W bits exported.
// A zero seed would lock the register, so it is replaced by all-ones.
module counter_chain_lfsr
    import counter_chain_pkg::*;
#(
    parameter int LFSR_W = 32,
    parameter int OPS_W  = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [LFSR_W-1:0] seed_i,
    input  logic              en_i,
    output logic [OPS_W-1:0]  ops_o
);
    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;
    logic              fb;

    // Next state: load wins over step; hold otherwise.
    always_comb begin
        fb     = lfsr_q[LFSR_TAP_A-1] ^ lfsr_q[LFSR_TAP_B-1] ^
                 lfsr_q[LFSR_TAP_C-1] ^ lfsr_q[LFSR_TAP_D-1];
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = (seed_i == '0) ? '1 : seed_i;
        end else if (en_i) begin
            lfsr_d = {lfsr_q[LFSR_W-2:0], fb};
        end
    end

    // State register, all-ones after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= '1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign ops_o = lfsr_q[OPS_W-1:0];
endmodule

// File: rtl/counter_chain_checker.sv
// Stimulus/response engine for the counter-chain wrapper: LFSR operands out,
// golden sum delayed DUT_LAT cycles and compared with the wrapper result O.
// Define CCC_ERRLOG_EN to add first_err_exp/first_err_obs capture outputs.
module counter_chain_checker
    import counter_chain_pkg::*;
#(
    parameter int LENGTH  = CCC_LENGTH,
    parameter int DUT_LAT = 2,
    parameter int CNT_W   = 16,
    parameter int LFSR_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LFSR_W-1:0]       seed,
    input  logic [CNT_W-1:0]        num_vectors,
    counter_chain_checker_if.master bus,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [CNT_W-1:0]        err_count,
    output logic [CNT_W-1:0]        first_err_idx
`ifdef CCC_ERRLOG_EN
    ,
    output logic [2*LENGTH+2:0]     first_err_exp,
    output logic [2*LENGTH+2:0]     first_err_obs
`endif
);
    localparam int               SW         = 2*LENGTH + 3;
    localparam int               OPS_W      = 6 + 5*LENGTH;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [3:0]       DRAIN_LAST = 4'(DUT_LAT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  vec_idx_q, vec_idx_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic [3:0]        drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0]  err_count_q, err_count_d;
    logic [CNT_W-1:0]  first_err_idx_q, first_err_idx_d;
    logic              pass_q, pass_d;
`ifdef CCC_ERRLOG_EN
    logic [SW-1:0]     err_exp_q, err_exp_d;
    logic [SW-1:0]     err_obs_q, err_obs_d;
`endif

    logic              accept;
    logic              issue;
    logic              last_issue;
    logic [OPS_W-1:0]  ops;
    logic [SW-1:0]     gold;

    // Golden/index delay line, one entry per cycle, tagged with issue-valid.
    logic              pipe_vld_q  [DUT_LAT];
    logic [SW-1:0]     pipe_gold_q [DUT_LAT];
    logic [CNT_W-1:0]  pipe_idx_q  [DUT_LAT];

    logic              cmp_vld;
    logic [SW-1:0]     cmp_gold;
    logic [CNT_W-1:0]  cmp_idx;
    logic              mismatch;

    assign accept     = start && ((state_q == IDLE) || (state_q == DONE));
    assign issue      = (state_q == RUN) && (num_q != '0);
    assign last_issue = issue && (vec_idx_q == (num_q - CNT_ONE));

    counter_chain_lfsr #(
        .LFSR_W (LFSR_W),
        .OPS_W  (OPS_W)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load_i (accept),
        .seed_i (seed),
        .en_i   (issue),
        .ops_o  (ops)
    );

    // Operand fields sliced LSB-upward; zero whenever no vector is issued.
    always_comb begin
        bus.C0    = '0;
        bus.C1    = 1'b0;
        bus.CL_00 = '0;
        bus.CL_01 = '0;
        bus.CL_02 = '0;
        bus.CL_03 = '0;
        bus.CL_10 = '0;
        if (issue) begin
            bus.C0    = ops[4:0];
            bus.C1    = ops[5];
            bus.CL_00 = ops[6            +: LENGTH];
            bus.CL_01 = ops[6 +   LENGTH +: LENGTH];
            bus.CL_02 = ops[6 + 2*LENGTH +: LENGTH];
            bus.CL_03 = ops[6 + 3*LENGTH +: LENGTH];
            bus.CL_10 = ops[6 + 4*LENGTH +: LENGTH];
        end
    end

    assign gold = golden_sum(bus.C0, bus.C1, bus.CL_00, bus.CL_01,
                             bus.CL_02, bus.CL_03, bus.CL_10);

    // Delay line aligning the golden value with the wrapper's registered output.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DUT_LAT; i++) begin
                pipe_vld_q[i]  <= 1'b0;
                pipe_gold_q[i] <= '0;
                pipe_idx_q[i]  <= '0;
            end
        end else begin
            pipe_vld_q[0]  <= issue;
            pipe_gold_q[0] <= gold;
            pipe_idx_q[0]  <= vec_idx_q;
            for (int i = 1; i < DUT_LAT; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_gold_q[i] <= pipe_gold_q[i-1];
                pipe_idx_q[i]  <= pipe_idx_q[i-1];
            end
        end
    end

    assign cmp_vld  = pipe_vld_q[DUT_LAT-1];
    assign cmp_gold = pipe_gold_q[DUT_LAT-1];
    assign cmp_idx  = pipe_idx_q[DUT_LAT-1];
    assign mismatch = cmp_vld && (bus.O != cmp_gold);

    // FSM next state and state-decoded status outputs.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (num_q == '0)     state_d = DONE;
                else if (last_issue) state_d = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_cnt_q == DRAIN_LAST) state_d = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (accept) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Run bookkeeping: vector index, drain timer, error statistics, verdict.
    always_comb begin
        vec_idx_d       = vec_idx_q;
        num_d           = num_q;
        err_count_d     = err_count_q;
        first_err_idx_d = first_err_idx_q;
        pass_d          = pass_q;
`ifdef CCC_ERRLOG_EN
        err_exp_d       = err_exp_q;
        err_obs_d       = err_obs_q;
`endif
        drain_cnt_d     = (state_q == DRAIN) ? (drain_cnt_q + 4'd1) : 4'd0;
        if (accept) begin
            vec_idx_d       = '0;
            num_d           = num_vectors;
            err_count_d     = '0;
            first_err_idx_d = '1;
            pass_d          = 1'b0;
`ifdef CCC_ERRLOG_EN
            err_exp_d       = '0;
            err_obs_d       = '0;
`endif
        end else begin
            if (issue) vec_idx_d = vec_idx_q + CNT_ONE;
            if (mismatch) begin
                if (err_count_q != '1) err_count_d = err_count_q + CNT_ONE;
                if (err_count_q == '0) begin
                    first_err_idx_d = cmp_idx;
`ifdef CCC_ERRLOG_EN
                    err_exp_d       = cmp_gold;
                    err_obs_d       = bus.O;
`endif
                end
            end
            // Verdict includes the final compare, which lands on the same edge.
            if ((state_d == DONE) && (state_q != DONE)) pass_d = (err_count_d == '0);
        end
    end

    // Control and statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            vec_idx_q       <= '0;
            num_q           <= '0;
            drain_cnt_q     <= '0;
            err_count_q     <= '0;
            first_err_idx_q <= '1;
            pass_q          <= 1'b0;
`ifdef CCC_ERRLOG_EN
            err_exp_q       <= '0;
            err_obs_q       <= '0;
`endif
        end else begin
            state_q         <= state_d;
            vec_idx_q       <= vec_idx_d;
            num_q           <= num_d;
            drain_cnt_q     <= drain_cnt_d;
            err_count_q     <= err_count_d;
            first_err_idx_q <= first_err_idx_d;
            pass_q          <= pass_d;
`ifdef CCC_ERRLOG_EN
            err_exp_q       <= err_exp_d;
            err_obs_q       <= err_obs_d;
`endif
        end
    end

    assign pass          = pass_q;
    assign err_count     = err_count_q;
    assign first_err_idx = first_err_idx_q;
`ifdef CCC_ERRLOG_EN
    assign first_err_exp = err_exp_q;
    assign first_err_obs = err_obs_q;
`endif
endmodule

// File: tb/tb_counter_chain_checker.sv
// Self-checking bench for counter_chain_checker: a behavioural wrapper with
// selectable fault modes drives O; a reference LFSR/golden model predicts results.
module tb_counter_chain_checker;
    localparam int L   = 5;
    localparam int LAT = 2;
    localparam int CW  = 16;
    localparam int LW  = 32;
    localparam int SW  = 2*L + 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] seed = '0;
    logic [CW-1:0] num_vectors = '0;
    logic          busy, done, pass;
    logic [CW-1:0] err_count, first_err_idx;
`ifdef CCC_ERRLOG_EN
    logic [SW-1:0] fe_exp, fe_obs;
`endif

    counter_chain_checker_if #(.LENGTH(L)) bus ();

    counter_chain_checker #(
        .LENGTH(L), .DUT_LAT(LAT), .CNT_W(CW), .LFSR_W(LW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .seed          (seed),
        .num_vectors   (num_vectors),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_idx (first_err_idx)
`ifdef CCC_ERRLOG_EN
        ,
        .first_err_exp (fe_exp),
        .first_err_obs (fe_obs)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural wrapper (the evaluated DUT) ----------------
    int          mode = 0;       // 0 ideal, 1 O bit0 forced high, 2 corrupt one vector
    int          inj_idx = 37;
    logic [SW-1:0] inj_xor = 13'h005;
    int          run_cyc = 0;
    int          wp_sum [LAT];
    int          wp_idx [LAT];
    logic [30:0] ops_obs;
    logic [SW-1:0] model_o;

    assign ops_obs = {bus.CL_10, bus.CL_03, bus.CL_02, bus.CL_01, bus.CL_00, bus.C1, bus.C0};

    always @(posedge clk) begin
        if (rst) begin
            run_cyc <= 0;
            for (int i = 0; i < LAT; i++) begin
                wp_sum[i] <= 0;
                wp_idx[i] <= -1;
            end
        end else begin
            if (start && !busy) run_cyc <= 0;
            else                run_cyc <= run_cyc + 1;
            wp_sum[0] <= int'(bus.CL_00) + int'(bus.CL_01) + int'(bus.CL_02) + int'(bus.CL_03)
                         + 2*int'(bus.CL_10) + $countones(bus.C0) + 2*int'(bus.C1);
            wp_idx[0] <= run_cyc;
            for (int i = 1; i < LAT; i++) begin
                wp_sum[i] <= wp_sum[i-1];
                wp_idx[i] <= wp_idx[i-1];
            end
        end
    end

    always_comb begin
        model_o = SW'(wp_sum[LAT-1]);
        if (mode == 1) model_o = model_o | SW'(1);
        else if (mode == 2 && wp_idx[LAT-1] == inj_idx) model_o = model_o ^ inj_xor;
    end
    assign bus.O = model_o;

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_next(input logic [31:0] s);
        logic fb;
        fb = s[31] ^ s[21] ^ s[1] ^ s[0];
        return (s << 1) | {31'd0, fb};
    endfunction

    function automatic int ref_golden(input logic [31:0] s);
        int g;
        g = $countones(s & 32'h1F) + 2*int'((s >> 5) & 32'h1);
        for (int k = 0; k < 4; k++) g += int'((s >> (6 + 5*k)) & 32'h1F);
        g += 2*int'((s >> 26) & 32'h1F);
        return g;
    endfunction

    // One complete run; poke >= 0 pulses start (with other settings) during RUN.
    task automatic do_run(input logic [31:0] sd, input int n, input int md, input int poke);
        logic [31:0] s;
        int exp_err, exp_first, g, lat_exp, c;
        logic [SW-1:0] exp_e, exp_o, obs_v;
        bit got;
        mode = md;
        seed = sd;
        num_vectors = CW'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        s = (sd == 0) ? 32'hFFFF_FFFF : sd;
        exp_err = 0; exp_first = 32'hFFFF; exp_e = '0; exp_o = '0;
        lat_exp = (n == 0) ? 1 : n + LAT;
        check_eq("busy_after_start", 32'(busy), 32'd1);
        check_eq("err_cleared_on_start", 32'(err_count), 32'd0);
        check_eq("done_low_after_start", 32'(done), 32'd0);
        got = 0;
        for (c = 0; c < n + LAT + 20; c++) begin
            if (done) begin
                got = 1;
                break;
            end
            if (c < n) begin
                check_eq("operands", 32'(ops_obs), s & 32'h7FFF_FFFF);
                g = ref_golden(s);
                obs_v = SW'(g);
                if (md == 1) obs_v = obs_v | SW'(1);
                if (md == 2 && c == inj_idx) obs_v = obs_v ^ inj_xor;
                if (obs_v != SW'(g)) begin
                    if (exp_err == 0) begin
                        exp_first = c; exp_e = SW'(g); exp_o = obs_v;
                    end
                    exp_err++;
                end
                s = ref_next(s);
            end else begin
                check_eq("operands_idle", 32'(ops_obs), 32'd0);
            end
            if (c == poke) begin
                seed = sd ^ 32'h5A5A_0001;
                num_vectors = CW'(n + 7);
                start = 1'b1;
            end
            tick();
            start = 1'b0;
        end
        check_eq("done_seen", 32'(got), 32'd1);
        if (got) check_eq("done_latency", 32'(c), 32'(lat_exp));
        check_eq("busy_in_done", 32'(busy), 32'd0);
        check_eq("pass", 32'(pass), (exp_err == 0) ? 32'd1 : 32'd0);
        check_eq("err_count", 32'(err_count), 32'(exp_err));
        check_eq("first_err_idx", 32'(first_err_idx), 32'(exp_first));
        check_eq("operands_done", 32'(ops_obs), 32'd0);
`ifdef CCC_ERRLOG_EN
        check_eq("first_err_exp", 32'(fe_exp), 32'(exp_e));
        check_eq("first_err_obs", 32'(fe_obs), 32'(exp_o));
`endif
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_pass"}, 32'(pass), 32'd0);
        check_eq({tag, "_err"}, 32'(err_count), 32'd0);
        check_eq({tag, "_first"}, 32'(first_err_idx), 32'hFFFF);
        check_eq({tag, "_ops"}, 32'(ops_obs), 32'd0);
`ifdef CCC_ERRLOG_EN
        check_eq({tag, "_exp"}, 32'(fe_exp), 32'd0);
        check_eq({tag, "_obs"}, 32'(fe_obs), 32'd0);
`endif
    endtask

    initial begin
        int n;
        repeat (3) tick();
        check_reset_values("reset");
        rst = 1'b0;
        tick();
        check_reset_values("idle");

        do_run(32'd1, 100, 0, -1);                 // ideal wrapper
        do_run($urandom, 80, 1, -1);               // O bit 0 stuck high
        do_run($urandom, 0, 0, -1);                // empty run
        inj_idx = 37; inj_xor = 13'h0A5;
        do_run($urandom, 50, 2, -1);               // single corrupted vector
        do_run(32'd0, 20, 0, -1);                  // zero seed becomes all-ones

        // Abort in the middle of a run, then replay the same seed.
        mode = 0; seed = 32'hACE1_1234; num_vectors = 16'd64; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        check_reset_values("abort");
        rst = 1'b0;
        tick();
        do_run(32'hACE1_1234, 64, 0, -1);

        // start during RUN is ignored; start from DONE clears the previous errors.
        do_run($urandom, 40, 1, 5);
        do_run($urandom, 30, 0, -1);

        for (int r = 0; r < 6; r++) begin
            n = int'($urandom_range(1, 60));
            inj_idx = int'($urandom_range(0, n - 1));
            inj_xor = SW'($urandom_range(1, (1 << SW) - 1));
            do_run($urandom, n, int'($urandom_range(0, 2)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
